// File: rtl/mmio_bus_decoder.sv
// Memory-mapped I/O decoder: matches requests against base/mask windows, sequences the
// device access with per-region wait states and a ready timeout, and returns one response.
module mmio_bus_decoder #(
    parameter int                      ADDR_W  = 16,
    parameter int                      DATA_W  = 32,
    parameter int                      N_REG   = 6,
    parameter logic [N_REG*ADDR_W-1:0] BASE    = {16'h1E04, 16'h1E00, 16'h1C0C, 16'h1C08, 16'h1C00, 16'h0800},
    parameter logic [N_REG*ADDR_W-1:0] MASK    = {16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFE, 16'hFFFF, 16'hF800},
    parameter logic [N_REG*4-1:0]      WAIT    = {4'd0, 4'd0, 4'd3, 4'd0, 4'd0, 4'd1},
    parameter int                      TIMEOUT = 15
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    input  logic [ADDR_W-1:0]       req_addr_i,
    input  logic                    req_we_i,
    input  logic [DATA_W-1:0]       req_wdata_i,
    output logic                    rsp_valid_o,
    output logic [DATA_W-1:0]       rsp_rdata_o,
    output logic                    rsp_err_o,
    output logic [N_REG-1:0]        sel_o,
    output logic [ADDR_W-1:0]       dev_addr_o,
    output logic                    dev_we_o,
    output logic [DATA_W-1:0]       dev_wdata_o,
    input  logic [N_REG*DATA_W-1:0] dev_rdata_i,
    input  logic [N_REG-1:0]        dev_ready_i
);

    // state     | meaning
    // ST_IDLE   | ready for a request, decode on accept
    // ST_ACCESS | region selected, burning wait states then waiting for dev_ready
    // ST_RESP   | one-cycle response strobe
    typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_RESP} state_t;

    localparam int IDX_W  = (N_REG > 1) ? $clog2(N_REG) : 1;
    localparam int TCNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [3:0]          wcnt_q, wcnt_d;
    logic [TCNT_W-1:0]   tcnt_q, tcnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                we_q, we_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                err_q, err_d;

    logic                hit_any;
    logic [IDX_W-1:0]    hit_idx;
    logic [3:0]          hit_wait;
    logic [DATA_W-1:0]   sel_rdata;
    logic                sel_ready;

    // Descending scan so the lowest hitting region wins on overlap.
    always_comb begin
        hit_any  = 1'b0;
        hit_idx  = '0;
        hit_wait = '0;
        for (int i = N_REG - 1; i >= 0; i--) begin
            if ((req_addr_i & MASK[i*ADDR_W +: ADDR_W]) == BASE[i*ADDR_W +: ADDR_W]) begin
                hit_any  = 1'b1;
                hit_idx  = IDX_W'(i);
                hit_wait = WAIT[i*4 +: 4];
            end
        end
    end

    always_comb begin
        sel_rdata = '0;
        sel_ready = 1'b0;
        sel_o     = '0;
        for (int i = 0; i < N_REG; i++) begin
            if (idx_q == IDX_W'(i)) begin
                sel_rdata = dev_rdata_i[i*DATA_W +: DATA_W];
                sel_ready = dev_ready_i[i];
                sel_o[i]  = (state_q == ST_ACCESS);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        wcnt_d  = wcnt_q;
        tcnt_d  = tcnt_q;
        addr_d  = addr_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        unique case (state_q)
            ST_IDLE: begin
                if (req_valid_i) begin
                    addr_d  = req_addr_i;
                    we_d    = req_we_i;
                    wdata_d = req_wdata_i;
                    tcnt_d  = '0;
                    if (hit_any) begin
                        idx_d   = hit_idx;
                        wcnt_d  = hit_wait;
                        state_d = ST_ACCESS;
                    end else begin
                        rdata_d = '0;
                        err_d   = 1'b1;
                        state_d = ST_RESP;
                    end
                end
            end
            ST_ACCESS: begin
                if (wcnt_q != 4'd0) begin
                    wcnt_d = wcnt_q - 4'd1;
                end else if (sel_ready) begin
                    rdata_d = we_q ? '0 : sel_rdata;
                    err_d   = 1'b0;
                    state_d = ST_RESP;
                end else if ((TIMEOUT != 0) && (tcnt_q == TCNT_W'(TIMEOUT))) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = ST_RESP;
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
            ST_RESP:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            wcnt_q  <= '0;
            tcnt_q  <= '0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            wcnt_q  <= wcnt_d;
            tcnt_q  <= tcnt_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign req_ready_o = (state_q == ST_IDLE);
    assign rsp_valid_o = (state_q == ST_RESP);
    assign rsp_rdata_o = rdata_q;
    assign rsp_err_o   = err_q;
    assign dev_addr_o  = addr_q;
    assign dev_wdata_o = wdata_q;
    assign dev_we_o    = we_q && (state_q == ST_ACCESS);

endmodule
